// File: rtl/fft_out_reorder.sv
// fft_out_reorder
// ---------------
// Takes the bit-reversed complex output stream of a streaming N-point FFT and
// re-emits each frame in natural bin order X[0]..X[N-1], using a two-bank
// (ping-pong) buffer. One bank fills while the other drains. A drain takes
// exactly N cycles, so back-to-back input frames give a continuous output
// stream and no backpressure is needed.
//
// Handshake: there is no ready on either side. in_valid marks a sample this
// cycle. out_valid marks a sample this cycle. Whenever out_valid is low, the
// data and framing outputs are held at zero.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid, in_sop  input sample strobe / first bit-reversed sample of frame
//   in_r, in_i        signed input components (bit-reversed order)
//   out_valid         output sample strobe
//   out_sop, out_eop  first (X[0]) / last (X[N-1]) bin of an output frame
//   out_r, out_i      signed output components (natural order)
//   frame_err         sticky: a partial frame was discarded by an early in_sop
//   dbg_state_o       reader FSM state (0 = IDLE, 1 = READ)
module fft_out_reorder #(
  parameter int N      = 128,
  parameter int LOG2N  = 7,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     in_sop,
  input  logic signed [DATA_W-1:0] in_r,
  input  logic signed [DATA_W-1:0] in_i,
  output logic                     out_valid,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic signed [DATA_W-1:0] out_r,
  output logic signed [DATA_W-1:0] out_i,
  output logic                     frame_err,
  output logic                     dbg_state_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } rd_state_e;

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int b = 0; b < LOG2N; b++) r[b] = a[LOG2N-1-b];
    return r;
  endfunction

  // Both banks live in one array; the bank select is the address MSB.
  logic [2*DATA_W-1:0] mem [2*N];

  // Write side state
  logic [LOG2N-1:0] wcnt_q, wcnt_d;
  logic             wbank_q, wbank_d;
  logic             synced_q, synced_d;
  logic             ferr_q, ferr_d;
  logic [1:0]       full_q, full_d;

  // Read side state
  rd_state_e        state_q, state_d;
  logic [LOG2N-1:0] rcnt_q, rcnt_d;
  logic             rbank_q, rbank_d;

  // Output registers
  logic                     out_valid_q, out_sop_q, out_eop_q;
  logic signed [DATA_W-1:0] out_r_q, out_i_q;

  logic             wr_sop, wr_en, wr_last;
  logic [LOG2N-1:0] wr_addr;
  logic [1:0]       set_mask, clr_mask;
  logic             rd_en;

  // ---------------- write side ----------------
  always_comb begin
    wr_sop   = in_valid & in_sop;
    wr_en    = in_valid & (in_sop | synced_q);
    // An in_sop always lands at address 0, even when it aborts a partial frame.
    wr_addr  = wr_sop ? '0 : bitrev(wcnt_q);
    wr_last  = wr_en & ~in_sop & (wcnt_q == LAST);
    set_mask = 2'b00;
    if (wr_last) set_mask[wbank_q] = 1'b1;

    wcnt_d   = wcnt_q;
    wbank_d  = wbank_q;
    synced_d = synced_q | wr_sop;
    ferr_d   = ferr_q | (wr_sop & (wcnt_q != '0));
    // The counter wraps to 0 naturally after the last entry.
    if (wr_en) wcnt_d = (wr_sop ? '0 : wcnt_q) + LOG2N'(1);
    if (wr_last) wbank_d = ~wbank_q;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[{wbank_q, wr_addr}] <= {in_r, in_i};
  end

  // ---------------- read side FSM ----------------
  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    rbank_d  = rbank_q;
    rd_en    = 1'b0;
    clr_mask = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (full_q[~wbank_q]) begin
          state_d = ST_READ;
          rcnt_d  = '0;
          rbank_d = ~wbank_q;
        end
      end
      ST_READ: begin
        rd_en  = 1'b1;
        rcnt_d = rcnt_q + LOG2N'(1);
        if (rcnt_q == LAST) begin
          clr_mask[rbank_q] = 1'b1;
          // Chain directly into the other bank when it is waiting, so
          // back-to-back frames leave the block with no gap cycle.
          if (full_q[~rbank_q]) begin
            rbank_d = ~rbank_q;
            rcnt_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Set and clear always target different banks.
    full_d = (full_q | set_mask) & ~clr_mask;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt_q      <= '0;
      wbank_q     <= 1'b0;
      synced_q    <= 1'b0;
      ferr_q      <= 1'b0;
      full_q      <= 2'b00;
      state_q     <= ST_IDLE;
      rcnt_q      <= '0;
      rbank_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
    end else begin
      wcnt_q      <= wcnt_d;
      wbank_q     <= wbank_d;
      synced_q    <= synced_d;
      ferr_q      <= ferr_d;
      full_q      <= full_d;
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      rbank_q     <= rbank_d;
      out_valid_q <= rd_en;
      out_sop_q   <= rd_en & (rcnt_q == '0);
      out_eop_q   <= rd_en & (rcnt_q == LAST);
      if (rd_en) begin
        {out_r_q, out_i_q} <= mem[{rbank_q, rcnt_q}];
      end else begin
        out_r_q <= '0;
        out_i_q <= '0;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_sop     = out_sop_q;
  assign out_eop     = out_eop_q;
  assign out_r       = out_r_q;
  assign out_i       = out_i_q;
  assign frame_err   = ferr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Testbench for fft_out_reorder: a small N=8 instance for the directed cases
// and a default N=128 instance for the back-to-back frame case.
module tb_fft_out_reorder;
  localparam int DW = 16;
  localparam int NS = 8;
  localparam int LS = 3;
  localparam int NB = 128;
  localparam int LB = 7;
  localparam int W  = 2 * DW + 2;  // {sop, eop, r, i}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // small instance
  logic          in_valid = 1'b0, in_sop = 1'b0;
  logic [DW-1:0] in_r = '0, in_i = '0;
  logic          out_valid, out_sop, out_eop, frame_err, dbg_state;
  logic [DW-1:0] out_r, out_i;

  // big instance
  logic          b_in_valid = 1'b0, b_in_sop = 1'b0;
  logic [DW-1:0] b_in_r = '0, b_in_i = '0;
  logic          b_out_valid, b_out_sop, b_out_eop, b_frame_err, b_dbg_state;
  logic [DW-1:0] b_out_r, b_out_i;

  fft_out_reorder #(.N(NS), .LOG2N(LS), .DATA_W(DW)) u_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop),
    .in_r(in_r), .in_i(in_i), .out_valid(out_valid), .out_sop(out_sop),
    .out_eop(out_eop), .out_r(out_r), .out_i(out_i), .frame_err(frame_err),
    .dbg_state_o(dbg_state)
  );

  fft_out_reorder #(.N(NB), .LOG2N(LB), .DATA_W(DW)) u_big (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_sop(b_in_sop),
    .in_r(b_in_r), .in_i(b_in_i), .out_valid(b_out_valid), .out_sop(b_out_sop),
    .out_eop(b_out_eop), .out_r(b_out_r), .out_i(b_out_i), .frame_err(b_frame_err),
    .dbg_state_o(b_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  bexp_q[$];
  logic [DW-1:0] part_r[$];
  logic [DW-1:0] part_i[$];
  bit synced = 0;
  bit model_err = 0;
  bit mon_en = 0;
  int brun = 0;
  int blast_run = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit reversal done with plain arithmetic.
  function automatic int bitrev(input int x, input int bits);
    int r = 0;
    for (int b = 0; b < bits; b++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  // Reference model: collect a frame in arrival order; once complete, output
  // bin j is the sample that arrived at position bitrev(j).
  task automatic model_push(input bit sop, input logic [DW-1:0] r, input logic [DW-1:0] i);
    if (sop) begin
      if (part_r.size() != 0) model_err = 1;
      part_r.delete();
      part_i.delete();
      synced = 1;
    end
    if (sop || synced) begin
      part_r.push_back(r);
      part_i.push_back(i);
    end
    if (part_r.size() == NS) begin
      for (int j = 0; j < NS; j++) begin
        int k = bitrev(j, LS);
        exp_q.push_back({j == 0, j == NS - 1, part_r[k], part_i[k]});
      end
      part_r.delete();
      part_i.delete();
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    part_r.delete();
    part_i.delete();
    synced = 0;
    model_err = 0;
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input bit v, input bit sop, input logic [DW-1:0] r, input logic [DW-1:0] i);
    in_valid = v;
    in_sop   = sop;
    in_r     = r;
    in_i     = i;
    @(posedge clk);
    if (v && rst_n) model_push(sop, r, i);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) drive(1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    b_in_valid = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drive_big(input bit sop, input logic [DW-1:0] r, input logic [DW-1:0] i);
    b_in_valid = 1'b1;
    b_in_sop   = sop;
    b_in_r     = r;
    b_in_i     = i;
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    b_in_sop   = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int c = 0;
    while ((exp_q.size() != 0 || out_valid) && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  task automatic random_frame();
    for (int k = 0; k < NS; k++) drive(1'b1, k == 0, DW'($urandom), DW'($urandom));
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        if (exp_q.size() == 0) check("unexpected_valid", out_valid, 0);
        else check("small_out", {out_sop, out_eop, out_r, out_i}, exp_q.pop_front());
      end else begin
        check("small_idle_zero", {out_sop, out_eop, out_r, out_i}, 0);
      end
      check("frame_err", frame_err, model_err);
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (b_out_valid) begin
        brun++;
        if (bexp_q.size() == 0) check("big_unexpected_valid", b_out_valid, 0);
        else check("big_out", {b_out_sop, b_out_eop, b_out_r, b_out_i}, bexp_q.pop_front());
      end else begin
        if (brun != 0) blast_run = brun;
        brun = 0;
        check("big_idle_zero", {b_out_sop, b_out_eop, b_out_r, b_out_i}, 0);
      end
    end
  end

  // ---------------- directed sequence ----------------
  logic [DW-1:0] ai[NB];
  logic [DW-1:0] bi[NB];

  initial begin
    // reset state
    do_reset();
    check("rst_valid", out_valid, 0);
    check("rst_sop", out_sop, 0);
    check("rst_eop", out_eop, 0);
    check("rst_r", out_r, 0);
    check("rst_i", out_i, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_state_idle", dbg_state, 0);
    check("rst_big_valid", b_out_valid, 0);
    mon_en = 1;

    // 1: ramp k = 0..7 on consecutive cycles, latency T+2
    for (int k = 0; k < NS; k++) drive(1'b1, k == 0, DW'(k), DW'(k));
    check("lat_t0_valid", out_valid, 0);
    idle(1);
    check("lat_t1_valid", out_valid, 0);
    idle(1);
    check("lat_t2_valid", out_valid, 1);
    check("lat_t2_sop", out_sop, 1);
    check("lat_t2_r", out_r, 0);
    wait_drain("drain_ramp");

    // 2: random in_valid gaps inside one frame
    for (int k = 0; k < NS; k++) begin
      for (int g = 0; g < 3 && $urandom_range(1, 0) == 1; g++) idle(1);
      drive(1'b1, k == 0, DW'(k), DW'(k));
    end
    check("gap_t0_valid", out_valid, 0);
    idle(1);
    check("gap_t1_valid", out_valid, 0);
    idle(1);
    check("gap_t2_valid", out_valid, 1);
    check("gap_t2_sop", out_sop, 1);
    wait_drain("drain_gaps");

    // 3: samples before any in_sop are dropped
    do_reset();
    for (int k = 0; k < 5; k++) drive(1'b1, 1'b0, DW'($urandom), DW'($urandom));
    idle(4);
    check("nosync_valid", out_valid, 0);
    random_frame();
    wait_drain("drain_after_nosync");

    // 4: early in_sop at wcnt=5 aborts the partial frame
    for (int k = 0; k < 5; k++) drive(1'b1, k == 0, DW'($urandom), DW'($urandom));
    check("pre_abort_err", frame_err, 0);
    random_frame();
    check("abort_err_set", frame_err, 1);
    wait_drain("drain_abort");
    random_frame();
    wait_drain("drain_post_abort");
    check("abort_err_sticky", frame_err, 1);

    // 5: reset during output streaming
    random_frame();
    idle(5);
    check("pre_rst_streaming", out_valid, 1);
    do_reset();
    check("midrst_valid", out_valid, 0);
    check("midrst_r", out_r, 0);
    check("midrst_err", frame_err, 0);
    idle(12);
    check("midrst_no_residual", out_valid, 0);
    random_frame();
    wait_drain("drain_post_rst");

    // 6: two back-to-back N=128 frames
    for (int k = 0; k < NB; k++) begin
      ai[k] = DW'($urandom);
      bi[k] = DW'($urandom);
    end
    for (int j = 0; j < NB; j++)
      bexp_q.push_back({j == 0, j == NB - 1, DW'(bitrev(j, LB) << 8), ai[bitrev(j, LB)]});
    for (int j = 0; j < NB; j++)
      bexp_q.push_back({j == 0, j == NB - 1, DW'(-(bitrev(j, LB) << 8)), bi[bitrev(j, LB)]});
    for (int k = 0; k < NB; k++) drive_big(k == 0, DW'(k << 8), ai[k]);
    for (int k = 0; k < NB; k++) drive_big(k == 0, DW'(-(k << 8)), bi[k]);
    begin
      int c = 0;
      while ((bexp_q.size() != 0 || b_out_valid) && c < 400) begin
        @(posedge clk);
        #1;
        c++;
      end
    end
    idle(2);
    check("big_drain", bexp_q.size(), 0);
    check("big_contiguous_run", blast_run, 2 * NB);
    check("big_frame_err", b_frame_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_out_reorder.md
Name: fft_out_reorder

Overview:
- Sits directly downstream of the streaming 128-point FFT core and consumes its complex output stream.
- The FFT core emits bins in bit-reversed order; this block captures each frame into a ping-pong buffer and re-emits it in natural bin order (X[0]..X[N-1]).
- It is the reader for the FFT output stream and adds framing (sop/eop/valid) for downstream consumers.

Parameters:
- N, 128, points per frame; must be a power of two.
- LOG2N, 7, log2(N); sets the address and counter width.
- DATA_W, 16, width of each real/imag component (signed).

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  in_r/in_i carry a sample this cycle.
- in_sop  input  1  with in_valid: first sample (bit-reversed index 0) of a frame.
- in_r  input  DATA_W  signed real part, bit-reversed order.
- in_i  input  DATA_W  signed imaginary part.
- out_valid  output  1  out_r/out_i valid.
- out_sop  output  1  first natural-order bin (X[0]) of a frame.
- out_eop  output  1  last bin (X[N-1]) of a frame.
- out_r  output  DATA_W  signed real part, natural order.
- out_i  output  DATA_W  signed imaginary part.
- frame_err  output  1  sticky: a frame was aborted by an early in_sop.

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0. wcnt=0, write bank=0, both bank-full flags cleared, reader IDLE, synced=0. Buffer contents are don't-care. Reset mid-frame discards all partial and pending frames.
- Storage: 2 banks x N entries x 2*DATA_W. Data passes through unchanged, with no scaling or rounding.
- Write side:
  - A sample with in_valid=1 and in_sop=1 sets synced=1 and is written at wcnt=0.
  - A sample with in_valid=1 and in_sop=0 is written only if synced=1; otherwise it is dropped.
  - Write address = bitrev_LOG2N(wcnt). wcnt increments on each accepted write.
  - When the write at wcnt=N-1 occurs: the bank-full flag is set, the write bank toggles, wcnt wraps to 0, and synced stays 1 (next in_sop expected).
  - in_valid=0 cycles (gaps) are allowed anywhere; wcnt holds.
- Early sop: in_sop=1 while wcnt!=0 discards the partial frame. wcnt restarts at 0 in the same bank, the sample is written at address 0, and frame_err is set (cleared only by reset).
- in_sop while in_valid=0 is ignored.
- Read side FSM:
  - IDLE: if the bank opposite the write bank is full, go to READ with rcnt=0 and rbank=that bank.
  - READ: issue a read at address rcnt each cycle. At rcnt=N-1, clear that bank's full flag and return to IDLE. If the other bank is already full, go straight to READ of the other bank with rcnt=0, with no gap cycle.
- Output pipeline: 1-cycle registered memory read.
  - out_valid is asserted the cycle after each read address is issued.
  - out_sop accompanies rcnt=0 data; out_eop accompanies rcnt=N-1 data.
  - Outputs are 0 when out_valid=0.
- Latency: last input sample accepted at edge T -> out_sop/out_valid at edge T+2. The frame then streams out over N consecutive cycles.
- Throughput: back-to-back input frames at 1 sample/cycle produce a continuous output. The reader drains one frame in N cycles while the other bank fills, so overflow cannot occur and no backpressure is provided.
- Simultaneous events: a bank-full set (writer) and a bank-full clear (reader) target different banks by construction. The reader checks the full flag as registered, so there is no same-cycle bypass.

Test Plan:
- N=8, DATA_W=16. Reset, then in_sop at first sample, in_r=in_i=k for k=0..7 on consecutive cycles -> out_r=out_i sequence 0,4,2,6,1,5,3,7. out_sop with first value, out_eop with last, and out_valid first high 2 cycles after k=7.
- N=128 default. Feed two back-to-back frames, frame A in_r=k<<8 and frame B in_r=-(k<<8) -> 256 contiguous out_valid cycles. Output j of A equals bitrev7(j)<<8, and B follows A with no gap.
- Random in_valid gaps (about 50% duty) within one N=8 frame -> the same 0,4,2,6,1,5,3,7 output, starting 2 cycles after the last valid sample.
- Samples with in_valid=1 before any in_sop -> dropped, out_valid stays 0. A subsequent proper frame reorders correctly.
- in_sop at wcnt=5 of a frame -> frame_err=1. Only the restarted frame is output (8 values), and frame_err stays 1 until rst_n=0.
- rst_n=0 for 1 cycle during output streaming -> all outputs 0 the next cycle and no residual output. The next full frame is output correctly.
